plic_target_ctx: RTL and testbench

Hart-side claim/complete agent for one PLIC context. Sits between `plic_core` (consumes its registered `irq_o`/`idx_o`, drives its `clam_i`/`comp_i`) and the hart's external-interrupt interface. It sequences claim, service and completion, keeps at most one interrupt outstanding, masks the hart request during service and post-completion hold-off, and flags completion errors and service timeouts.

---
 rtl/plic_target_ctx_pkg.sv | 17 +
 rtl/plic_sat_cnt.sv | 32 +++
 rtl/plic_target_ctx.sv | 160 ++++++++++++++++
 tb/tb_plic_target_ctx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/plic_target_ctx_pkg.sv
// Shared constants for the PLIC target context: state encodings, default widths
// and the timeout-counter sizing helper.
package plic_target_ctx_pkg;

    localparam int PLIC_IRQ_WIDTH   = 8;
    localparam int PLIC_CTX_TIMEOUT = 1024;

    localparam logic [1:0] CTX_IDLE    = 2'd0;
    localparam logic [1:0] CTX_SERVICE = 2'd1;
    localparam logic [1:0] CTX_HOLD    = 2'd2;

    // The limit itself must be representable; a limit of 0 still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/plic_sat_cnt.sv
// Up-counter with synchronous clear and enable that stops at LIMIT;
// hit_o is high while the count sits at LIMIT.
module plic_sat_cnt #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/plic_target_ctx.sv
// Hart-side claim/complete agent for one PLIC context: sequences claim, service
// and completion, masks meip during service and hold-off, flags errors/timeouts.
module plic_target_ctx
    import plic_target_ctx_pkg::*;
#(
    parameter int IRQ_WIDTH = PLIC_IRQ_WIDTH,
    parameter int HOLDOFF   = 2,
    parameter int TIMEOUT   = PLIC_CTX_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 irq_i,
    input  logic [IRQ_WIDTH-1:0] idx_i,
    output logic                 clam_o,
    output logic                 comp_o,
    output logic [IRQ_WIDTH-1:0] comp_idx_o,
    output logic                 meip_o,
    input  logic                 claim_req_i,
    output logic                 claim_ack_o,
    output logic [IRQ_WIDTH-1:0] claim_id_o,
    input  logic                 comp_req_i,
    input  logic [IRQ_WIDTH-1:0] comp_id_i,
    output logic                 comp_ack_o,
    output logic                 err_o,
    output logic                 tmo_o
);

    localparam int   TMO_W  = cnt_width(TIMEOUT);
    localparam logic TMO_EN = (TIMEOUT != 0);

    logic [1:0]           state_q, state_d;
    logic [IRQ_WIDTH-1:0] cur_id_q, cur_id_d;
    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic                 claim_ack_q, claim_ack_d;
    logic [IRQ_WIDTH-1:0] claim_id_q, claim_id_d;
    logic                 clam_q, clam_d;
    logic                 comp_ack_q, comp_ack_d;
    logic                 comp_q, comp_d;
    logic [IRQ_WIDTH-1:0] comp_idx_q, comp_idx_d;
    logic                 err_q, err_d;
    logic                 meip_q, meip_d;
    logic                 tmo_q, tmo_d;

    logic has_irq;
    logic cnt_clr;
    logic tmo_cnt_en;
    logic tmo_hit;

    assign has_irq    = irq_i && (idx_i != '0);
    assign tmo_cnt_en = TMO_EN && (state_q == CTX_SERVICE);

    plic_sat_cnt #(
        .WIDTH (TMO_W),
        .LIMIT (TMO_W'(TIMEOUT))
    ) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (tmo_cnt_en),
        .hit_o (tmo_hit)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        hold_cnt_d  = hold_cnt_q;
        claim_ack_d = claim_req_i;
        claim_id_d  = '0;
        clam_d      = 1'b0;
        comp_ack_d  = comp_req_i;
        comp_d      = 1'b0;
        comp_idx_d  = '0;
        err_d       = 1'b0;
        cnt_clr     = 1'b0;
        tmo_d       = tmo_q | (tmo_cnt_en && tmo_hit);

        case (state_q)
            CTX_IDLE: begin
                err_d = comp_req_i;
                if (claim_req_i && has_irq) begin
                    cur_id_d   = idx_i;
                    claim_id_d = idx_i;
                    clam_d     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_d    = CTX_SERVICE;
                end
            end
            CTX_SERVICE: begin
                if (comp_req_i) begin
                    if (comp_id_i == cur_id_q) begin
                        comp_d     = 1'b1;
                        comp_idx_d = cur_id_q;
                        cur_id_d   = '0;
                        tmo_d      = 1'b0;
                        cnt_clr    = 1'b1;
                        hold_cnt_d = 4'(HOLDOFF);
                        state_d    = CTX_HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CTX_HOLD: begin
                err_d      = comp_req_i;
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q <= 4'd1) begin
                    hold_cnt_d = '0;
                    state_d    = CTX_IDLE;
                end
            end
            default: state_d = CTX_IDLE;
        endcase

        // Looking at the next state lets meip reopen on the first IDLE cycle after hold-off.
        meip_d = (state_d == CTX_IDLE) && has_irq;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CTX_IDLE;
            cur_id_q    <= '0;
            hold_cnt_q  <= '0;
            claim_ack_q <= 1'b0;
            claim_id_q  <= '0;
            clam_q      <= 1'b0;
            comp_ack_q  <= 1'b0;
            comp_q      <= 1'b0;
            comp_idx_q  <= '0;
            err_q       <= 1'b0;
            meip_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            hold_cnt_q  <= hold_cnt_d;
            claim_ack_q <= claim_ack_d;
            claim_id_q  <= claim_id_d;
            clam_q      <= clam_d;
            comp_ack_q  <= comp_ack_d;
            comp_q      <= comp_d;
            comp_idx_q  <= comp_idx_d;
            err_q       <= err_d;
            meip_q      <= meip_d;
            tmo_q       <= tmo_d;
        end
    end

    assign claim_ack_o = claim_ack_q;
    assign claim_id_o  = claim_id_q;
    assign clam_o      = clam_q;
    assign comp_ack_o  = comp_ack_q;
    assign comp_o      = comp_q;
    assign comp_idx_o  = comp_idx_q;
    assign err_o       = err_q;
    assign meip_o      = meip_q;
    assign tmo_o       = tmo_q;

endmodule

// File: tb/tb_plic_target_ctx.sv
// Scoreboard bench for plic_target_ctx: each request pushes its expected response,
// a negedge monitor pops and compares it in the response cycle.
module tb_plic_target_ctx;

    localparam int W = 8;

    typedef struct {
        int           cyc;
        logic         claim_ack;
        logic [W-1:0] claim_id;
        logic         clam;
        logic         comp_ack;
        logic         comp;
        logic [W-1:0] comp_idx;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         irq = 1'b0;
    logic [W-1:0] idx = '0;
    logic         claim_req = 1'b0;
    logic         comp_req = 1'b0;
    logic [W-1:0] comp_id = '0;

    logic         clam_o, comp_o, meip_o, claim_ack_o, comp_ack_o, err_o, tmo_o;
    logic [W-1:0] comp_idx_o, claim_id_o;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    plic_target_ctx #(
        .IRQ_WIDTH (W),
        .HOLDOFF   (2),
        .TIMEOUT   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_i       (irq),
        .idx_i       (idx),
        .clam_o      (clam_o),
        .comp_o      (comp_o),
        .comp_idx_o  (comp_idx_o),
        .meip_o      (meip_o),
        .claim_req_i (claim_req),
        .claim_ack_o (claim_ack_o),
        .claim_id_o  (claim_id_o),
        .comp_req_i  (comp_req),
        .comp_id_i   (comp_id),
        .comp_ack_o  (comp_ack_o),
        .err_o       (err_o),
        .tmo_o       (tmo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic ca, input logic [W-1:0] cid, input logic cl,
                                input logic pa, input logic pc, input logic [W-1:0] pidx,
                                input logic er);
        exp_t e;
        e.cyc = 0; e.claim_ack = ca; e.claim_id = cid; e.clam = cl;
        e.comp_ack = pa; e.comp = pc; e.comp_idx = pidx; e.err = er;
        return e;
    endfunction

    // Called at a negedge; the request is sampled at the next posedge and answered one cycle later.
    task automatic drive(input logic clm, input logic cmp, input logic [W-1:0] cid, input exp_t e);
        claim_req = clm;
        comp_req  = cmp;
        comp_id   = cid;
        e.cyc     = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        claim_req = 1'b0;
        comp_req  = 1'b0;
        comp_id   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("claim_ack", 32'(claim_ack_o), 32'(e.claim_ack));
            check("claim_id",  32'(claim_id_o),  32'(e.claim_id));
            check("clam",      32'(clam_o),      32'(e.clam));
            check("comp_ack",  32'(comp_ack_o),  32'(e.comp_ack));
            check("comp",      32'(comp_o),      32'(e.comp));
            check("comp_idx",  32'(comp_idx_o),  32'(e.comp_idx));
            check("err",       32'(err_o),       32'(e.err));
        end else begin
            check("no_strobe", 32'({claim_ack_o, clam_o, comp_ack_o, comp_o, err_o,
                                    claim_id_o, comp_idx_o}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_meip", 32'(meip_o), 32'd0);
        check("rst_tmo",  32'(tmo_o),  32'd0);
        rst = 1'b0;
        irq = 1'b1;
        idx = 8'd5;
        idle(6);
        check("idle_meip_follows", 32'(meip_o), 32'd1);

        // Claim ID 5, then a wrong completion, then the right one back-to-back.
        drive(1, 0, '0, mk(1, 8'd5, 1, 0, 0, '0, 0));
        check("meip_masked_service", 32'(meip_o), 32'd0);
        drive(0, 1, 8'd3, mk(0, '0, 0, 1, 0, '0, 1));
        drive(0, 1, 8'd5, mk(0, '0, 0, 1, 1, 8'd5, 0));
        check("hold_meip_1", 32'(meip_o), 32'd0);
        check("tmo_not_set", 32'(tmo_o), 32'd0);
        drive(0, 1, 8'd5, mk(0, '0, 0, 1, 0, '0, 1));
        check("hold_meip_2", 32'(meip_o), 32'd0);
        idle(1);
        check("meip_reopens", 32'(meip_o), 32'd1);

        // IDLE with no request: claim returns 0, completion errors.
        irq = 1'b0;
        drive(1, 0, '0, mk(1, '0, 0, 0, 0, '0, 0));
        check("meip_low_no_irq", 32'(meip_o), 32'd0);
        drive(0, 1, 8'd5, mk(0, '0, 0, 1, 0, '0, 1));

        // IDLE simultaneous: claim taken, completion rejected.
        irq = 1'b1;
        idx = 8'd7;
        drive(1, 1, 8'd7, mk(1, 8'd7, 1, 1, 0, '0, 1));
        drive(1, 0, '0, mk(1, '0, 0, 0, 0, '0, 0));
        // SERVICE simultaneous: completion accepted, claim returns 0.
        drive(1, 1, 8'd7, mk(1, '0, 0, 1, 1, 8'd7, 0));
        idle(3);

        // Timeout: acked in cycle E+1, counter hits 8 after edge E+8, flag visible from E+10.
        idx = 8'd4;
        drive(1, 0, '0, mk(1, 8'd4, 1, 0, 0, '0, 0));
        idle(8);
        check("tmo_before_limit", 32'(tmo_o), 32'd0);
        idle(1);
        check("tmo_at_limit", 32'(tmo_o), 32'd1);
        idle(5);
        check("tmo_sticky", 32'(tmo_o), 32'd1);
        check("meip_masked_long", 32'(meip_o), 32'd0);
        drive(0, 1, 8'd4, mk(0, '0, 0, 1, 1, 8'd4, 0));
        check("tmo_cleared", 32'(tmo_o), 32'd0);
        idle(3);

        // Reset mid-SERVICE drops the claim without a completion.
        drive(1, 0, '0, mk(1, 8'd4, 1, 0, 0, '0, 0));
        idle(2);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'({clam_o, comp_o, meip_o, claim_ack_o, comp_ack_o, err_o, tmo_o,
                                       claim_id_o, comp_idx_o}), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(2);
        check("post_rst_meip", 32'(meip_o), 32'd1);
        drive(0, 1, 8'd4, mk(0, '0, 0, 1, 0, '0, 1));
        idle(2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
